onchip_mem_arbiter: RTL
=======================

// Module: onchip_mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter in front of the single-port 32-bit on-chip RAM.
//  Shares the RAM's one Avalon-MM port between m0 (Nios II data master) and m1 (DMA/debug master).
//  Forwards one command per cycle and tracks read latency.
//  Routes each readdata/readdatavalid back to the master that issued the read.
// PARAMETERS
//  ADDR_W      16  word address width (RAM depth 2**ADDR_W words)
//  DATA_W      32  data width; BE_W = DATA_W/8 byteenable bits
//  RD_LATENCY  1   cycles from accepted read to mem_readdata valid (1..4)
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       synchronous reset, active low
//  mX_address       in   ADDR_W  word address, X = 0,1
//  mX_read          in   1       read request
//  mX_write         in   1       write request
//  mX_writedata     in   DATA_W  write data
//  mX_byteenable    in   BE_W    byte lanes for write
//  mX_waitrequest   out  1       1 = command not accepted this cycle, hold it
//  mX_readdata      out  DATA_W  read data returned to master X
//  mX_readdatavalid out  1       mX_readdata valid this cycle
//  mem_address      out  ADDR_W  to RAM address
//  mem_chipselect   out  1       RAM access this cycle
//  mem_write        out  1       RAM write strobe
//  mem_writedata    out  DATA_W  to RAM write data
//  mem_byteenable   out  BE_W    to RAM byte enables; all-ones on reads
//  mem_clken        out  1       RAM clock enable; 1 out of reset
//  mem_readdata     in   DATA_W  from RAM
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge):
//   - Outputs: mX_waitrequest=1, mX_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
//   - last_grant=1, so m0 has priority first.
//   - Read-tag pipeline cleared; in-flight reads are dropped and never signalled.
//  Request: reqX = mX_read | mX_write. If both are asserted, the access is a write; the read is ignored.
//  Grant is combinational from reqX and registered last_grant:
//   - Only one requester: it wins.
//   - Both: the master != last_grant wins.
//   - None: no grant; last_grant is unchanged.
//  Winner: mX_waitrequest=0; its command drives mem_* in the same cycle (mem_chipselect=1).
//  Loser or idle master: mX_waitrequest=1. The master must hold its command stable.
//  last_grant <= winner at each clk with a grant. Back-to-back contention alternates m0,m1,m0...
//  Single requester may issue every cycle; throughput is 1 access/clk, no bubbles.
//  Idle: mem_chipselect=0, mem_write=0. mem_address/mem_writedata hold their last value.
//  Read tracking: shift register of depth RD_LATENCY holding {valid,id}.
//   - Accepted read pushes {1,winner}; writes and idle push {0,x}.
//   - At pipeline output: mid_readdatavalid=1 for one cycle; both mX_readdata = mem_readdata.
//   - Reads return in issue order with exact latency RD_LATENCY; no backpressure on read data.
//  Write then read of the same address by the other master on the next cycle returns the new data
//  (commands are serialised at the RAM).
//  Reset asserted mid-read: the pending tag is flushed and no readdatavalid is produced.
//  After reset release, the first grant is possible on the first cycle with reset_n=1.
// TESTING
//  1 Reset: hold reset_n=0 for 3 clk with m0_read=1 -> waitrequests=1, no mem_chipselect, no readdatavalid.
//  2 m0 writes 0xDEADBEEF at 0x0010 with be=4'b1111, then reads 0x0010
//    -> each waitrequest=0 in 1 clk; m0_readdatavalid 1 clk after the read with 0xDEADBEEF.
//  3 Both masters request every cycle for 8 clk
//    -> grants alternate m0,m1,..., starting m0 after reset; each gets exactly 4 accepts.
//  4 m0 reads 0x0001, then m1 reads 0x0002 on the next cycle (RD_LATENCY=2)
//    -> valids route to the correct master, in order, 2 clk after each accept.
//  5 m1 writes 0x000000AA at 0x0020 with be=4'b0001 over old 0x11223344; m0 reads 0x0020 next cycle
//    -> 0x112233AA.
//  6 Accept m0 read, assert reset_n=0 on the next clk -> m0_readdatavalid never asserts.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter sharing one single-port on-chip RAM Avalon-MM port.
// Latency: grant and command forwarding are combinational; read data returns RD_LATENCY clk after accept.
// Backpressure: the losing or idle master sees waitrequest=1 and holds its command; read data has no backpressure.
module onchip_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0 (CPU data master)
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1 (DMA / debug master)
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              req0;
  logic              req1;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              last_grant;   // 0 = m0 won last, 1 = m1 won last
  logic              win_write;
  logic              rd_accept;
  logic [ADDR_W-1:0] win_address;
  logic [DATA_W-1:0] win_writedata;
  logic [BE_W-1:0]   win_byteenable;
  logic [ADDR_W-1:0] address_hold;
  logic [DATA_W-1:0] writedata_hold;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [RD_LATENCY-1:0] tag_id;
  logic              out_vld;

  // A write request takes precedence over a simultaneous read from the same master.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin grant; held off entirely while reset_n is low so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (req0 && (!req1 || last_grant)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  // Winner command mux.
  always_comb begin
    win_address    = m1_address;
    win_writedata  = m1_writedata;
    win_byteenable = m1_byteenable;
    win_write      = m1_write;
    if (gnt0) begin
      win_address    = m0_address;
      win_writedata  = m0_writedata;
      win_byteenable = m0_byteenable;
      win_write      = m0_write;
    end
  end

  assign rd_accept = (gnt0 & ~m0_write) | (gnt1 & ~m1_write);

  // Remember who won; reset leaves m1 as last winner so m0 goes first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  // Keep the RAM address/data buses quiet (last value) between accesses; pure datapath, no reset.
  always_ff @(posedge clk) begin
    if (any_gnt) begin
      address_hold   <= win_address;
      writedata_hold <= win_writedata;
    end
  end

  assign mem_address    = any_gnt ? win_address : address_hold;
  assign mem_writedata  = any_gnt ? win_writedata : writedata_hold;
  assign mem_chipselect = any_gnt;
  assign mem_write      = any_gnt & win_write;
  assign mem_byteenable = mem_write ? win_byteenable : {BE_W{1'b1}};
  assign mem_clken      = reset_n;

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Read tag pipeline {valid,id}, one stage per cycle of RAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= rd_accept;
      tag_id[0]  <= gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Gated by reset_n so a tag maturing in the reset cycle itself is never signalled.
  assign out_vld          = tag_vld[RD_LATENCY-1] & reset_n;
  assign m0_readdatavalid = out_vld & ~tag_id[RD_LATENCY-1];
  assign m1_readdatavalid = out_vld &  tag_id[RD_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
